// File: rtl/bandit_egreedy.sv
// Epsilon-greedy multi-armed bandit: clears a value table, scans for the best arm, offers it and learns from the reward.
// Define BANDIT_EXPLORE_EN to build the exploration LFSR; without it every action is greedy.
module bandit_egreedy #(
    parameter int          ARMS       = 256,
    parameter int          DATA_WIDTH = 16,
    parameter int          STEP       = 3,
    parameter logic [31:0] SEED       = 32'hACE1_2018
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                reward_valid,
    input  logic signed [DATA_WIDTH-1:0]        reward_data,
    output logic                                reward_ready,
    output logic                                action_valid,
    output logic [$clog2(ARMS)-1:0]             action_data,
    input  logic                                action_ready,
    input  logic [7:0]                          epsilon
);

    localparam int INDEX_WIDTH = $clog2(ARMS);
    localparam int CNT_W       = INDEX_WIDTH + 1;

    typedef enum logic [2:0] {INIT, SCAN, OFFER, WAIT, UPDATE} state_t;

    state_t                        state;
    state_t                        state_next;
    logic [CNT_W-1:0]              cnt;
    logic                          cnt_run;

    logic signed [DATA_WIDTH-1:0]  value_table [ARMS];
    logic                          mem_we;
    logic [INDEX_WIDTH-1:0]        mem_waddr;
    logic signed [DATA_WIDTH-1:0]  mem_wdata;
    logic [INDEX_WIDTH-1:0]        rd_addr;
    logic signed [DATA_WIDTH-1:0]  rd_data_p1;

    logic signed [DATA_WIDTH-1:0]  best_val;
    logic [INDEX_WIDTH-1:0]        best_idx;
    logic signed [DATA_WIDTH-1:0]  reward_q;
    logic signed [DATA_WIDTH-1:0]  q_next;

    logic [CNT_W-1:0]              cand_full;
    logic [INDEX_WIDTH-1:0]        cand_idx;
    logic                          scan_first;
    logic                          scan_last;
    logic                          take;
    logic [INDEX_WIDTH-1:0]        greedy_idx;

    logic                          explore;
    logic [INDEX_WIDTH-1:0]        explore_idx;

    // Q + ((R - Q) >>> STEP); the result lies between Q and R so truncation cannot overflow.
    function automatic logic signed [DATA_WIDTH-1:0] update_value(
        input logic signed [DATA_WIDTH-1:0] q,
        input logic signed [DATA_WIDTH-1:0] r
    );
        logic signed [DATA_WIDTH:0] diff;
        logic signed [DATA_WIDTH:0] shifted;
        logic signed [DATA_WIDTH:0] sum;
        diff    = {r[DATA_WIDTH-1], r} - {q[DATA_WIDTH-1], q};
        shifted = diff >>> STEP;
        sum     = {q[DATA_WIDTH-1], q} + shifted;
        return sum[DATA_WIDTH-1:0];
    endfunction

`ifdef BANDIT_EXPLORE_EN
    logic [31:0] lfsr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lfsr <= SEED;
        end else begin
            lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? 32'h8020_0003 : 32'h0000_0000);
        end
    end

    assign explore     = lfsr[7:0] < epsilon;
    assign explore_idx = lfsr[8 +: INDEX_WIDTH];
`else
    logic unused_epsilon;
    assign unused_epsilon = ^epsilon;
    assign explore        = 1'b0;
    assign explore_idx    = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INIT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        action_valid = 1'b0;
        reward_ready = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = action_data;
        mem_wdata    = q_next;
        rd_addr      = action_data;
        case (state)
            INIT: begin
                mem_we    = 1'b1;
                mem_waddr = cnt[INDEX_WIDTH-1:0];
                mem_wdata = '0;
                if (cnt == CNT_W'(ARMS - 1)) state_next = SCAN;
            end
            SCAN: begin
                rd_addr = cnt[INDEX_WIDTH-1:0];
                if (scan_last) state_next = OFFER;
            end
            OFFER: begin
                action_valid = 1'b1;
                if (action_ready) state_next = WAIT;
            end
            WAIT: begin
                reward_ready = 1'b1;
                if (reward_valid) state_next = UPDATE;
            end
            UPDATE: begin
                mem_we     = 1'b1;
                state_next = SCAN;
            end
            default: state_next = INIT;
        endcase
    end

    assign cnt_run = (state == INIT && state_next == INIT) || (state == SCAN && state_next == SCAN);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (cnt_run) begin
            cnt <= cnt + CNT_W'(1);
        end else begin
            cnt <= '0;
        end
    end

    // Read stage: table output lags the scan address by one cycle.
    always_ff @(posedge clock) begin
        if (mem_we) value_table[mem_waddr] <= mem_wdata;
        rd_data_p1 <= value_table[rd_addr];
    end

    assign q_next     = update_value(rd_data_p1, reward_q);
    assign cand_full  = cnt - CNT_W'(1);
    assign cand_idx   = cand_full[INDEX_WIDTH-1:0];
    assign scan_first = (cnt == CNT_W'(1));
    assign scan_last  = (cnt == CNT_W'(ARMS));
    assign take       = scan_first || (rd_data_p1 > best_val);
    assign greedy_idx = take ? cand_idx : best_idx;

    // Compare stage: fold the entry that just arrived into the running best.
    always_ff @(posedge clock) begin
        if (state == SCAN && cnt != '0) begin
            if (take) best_val <= rd_data_p1;
            best_idx <= greedy_idx;
        end
        if (state == WAIT && reward_valid) reward_q <= reward_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            action_data <= '0;
        end else if (state == SCAN && scan_last) begin
            action_data <= explore ? explore_idx : greedy_idx;
        end
    end

endmodule

// File: tb/tb_bandit_egreedy.sv
// Scoreboard bench for bandit_egreedy with ARMS=4, STEP=3: greedy choices, update arithmetic, stalls, reset and exploration.
module tb_bandit_egreedy;

    localparam int ARMS = 4;
    localparam int DW   = 16;

    logic                 clock;
    logic                 reset;
    logic                 reward_valid;
    logic signed [DW-1:0] reward_data;
    logic                 reward_ready;
    logic                 action_valid;
    logic [1:0]           action_data;
    logic                 action_ready;
    logic [7:0]           epsilon;

    int n_cmp = 0;
    int n_bad = 0;
    int model [ARMS];
    int exp_q [$];

    bandit_egreedy #(.ARMS(ARMS), .DATA_WIDTH(DW), .STEP(3), .SEED(32'hACE1_2018)) dut (
        .clock        (clock),
        .reset        (reset),
        .reward_valid (reward_valid),
        .reward_data  (reward_data),
        .reward_ready (reward_ready),
        .action_valid (action_valid),
        .action_data  (action_data),
        .action_ready (action_ready),
        .epsilon      (epsilon)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // q + floor((r - q) / 8), written with integer division rather than shifts.
    function automatic int model_update(input int q, input int r);
        int d;
        int s;
        d = r - q;
        if (d >= 0) s = d / 8;
        else        s = -((-d + 7) / 8);
        return q + s;
    endfunction

    function automatic int model_greedy();
        int b;
        b = 0;
        for (int i = 1; i < ARMS; i++) if (model[i] > model[b]) b = i;
        return b;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ARMS; i++) model[i] = 0;
        exp_q.delete();
        exp_q.push_back(0);
    endtask

    task automatic apply_reset();
        @(negedge clock);
        #2 reset = 1'b0;
        action_ready = 1'b0;
        reward_valid = 1'b0;
        repeat (2) @(negedge clock);
        model_clear();
        reset = 1'b1;
    endtask

    task automatic wait_action(output bit ok, output int cycles);
        ok = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clock);
            if (action_valid === 1'b1) begin
                ok = 1'b1;
                cycles = i;
                break;
            end
        end
    endtask

    task automatic accept_action();
        action_ready = 1'b1;
        @(negedge clock);
        action_ready = 1'b0;
    endtask

    task automatic give_reward(input int r, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (reward_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (ok) begin
            reward_valid = 1'b1;
            reward_data  = 16'(r);
            @(negedge clock);
            reward_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        int cyc;
        int e;
        bit ok;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (action_valid !== 1'b0) begin n_bad++; $display("FAIL reset_action_valid got %b want 0", action_valid); end
        n_cmp++;
        if (action_data !== 2'd0) begin n_bad++; $display("FAIL reset_action_data got %0d want 0", action_data); end
        n_cmp++;
        if (reward_ready !== 1'b0) begin n_bad++; $display("FAIL reset_reward_ready got %b want 0", reward_ready); end
        repeat (2) @(negedge clock);
        model_clear();
        reset = 1'b1;
        wait_action(ok, cyc);
        n_cmp++;
        if (!ok || cyc != 2 * ARMS + 1) begin n_bad++; $display("FAIL first_action_latency got %0d want %0d", cyc, 2 * ARMS + 1); end
        e = exp_q.pop_front();
        n_cmp++;
        if (action_data !== 2'(e)) begin n_bad++; $display("FAIL first_action_data got %0d want %0d", action_data, e); end
    endtask

    task automatic test_update_positive();
        bit ok;
        int cyc;
        int e;
        logic signed [DW-1:0] obs;
        accept_action();
        give_reward(800, ok);
        model[0] = model_update(model[0], 800);
        exp_q.push_back(model_greedy());
        wait_action(ok, cyc);
        obs = dut.value_table[0];
        n_cmp++;
        if (obs !== 16'(model[0]) || model[0] != 100) begin n_bad++; $display("FAIL pos_update got %0d want 100", obs); end
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || action_data !== 2'(e)) begin n_bad++; $display("FAIL pos_next_action got %0d want %0d", action_data, e); end
    endtask

    task automatic test_update_negative();
        bit ok;
        int cyc;
        int e;
        logic signed [DW-1:0] obs;
        apply_reset();
        wait_action(ok, cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || action_data !== 2'(e)) begin n_bad++; $display("FAIL neg_first_action got %0d want %0d", action_data, e); end
        accept_action();
        give_reward(-800, ok);
        model[0] = model_update(model[0], -800);
        exp_q.push_back(model_greedy());
        wait_action(ok, cyc);
        obs = dut.value_table[0];
        n_cmp++;
        if (obs !== -16'sd100) begin n_bad++; $display("FAIL neg_update got %0d want -100", obs); end
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || action_data !== 2'(e) || e != 1) begin n_bad++; $display("FAIL neg_next_action got %0d want 1", action_data); end
    endtask

    task automatic test_stall();
        logic [1:0] held;
        logic signed [DW-1:0] obs;
        held = action_data;
        action_ready = 1'b0;
        reward_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            reward_data = 16'($urandom_range(0, 4000) - 2000);
            @(negedge clock);
            n_cmp++;
            if (action_valid !== 1'b1 || action_data !== held) begin
                n_bad++; $display("FAIL stall_action cyc %0d got v=%b d=%0d want v=1 d=%0d", i, action_valid, action_data, held);
            end
            n_cmp++;
            if (reward_ready !== 1'b0) begin n_bad++; $display("FAIL stall_reward_ready cyc %0d got %b want 0", i, reward_ready); end
        end
        reward_valid = 1'b0;
        for (int i = 0; i < ARMS; i++) begin
            obs = dut.value_table[i];
            n_cmp++;
            if (obs !== 16'(model[i])) begin n_bad++; $display("FAIL stall_table[%0d] got %0d want %0d", i, obs, model[i]); end
        end
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        int cyc;
        int e;
        int rw [3] = '{-800, -800, 800};
        logic signed [DW-1:0] obs;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            wait_action(ok, cyc);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || action_data !== 2'(e)) begin n_bad++; $display("FAIL rw_action[%0d] got %0d want %0d", k, action_data, e); end
            accept_action();
            give_reward(rw[k], ok);
            model[e] = model_update(model[e], rw[k]);
            exp_q.push_back(model_greedy());
        end
        wait_action(ok, cyc);
        obs = dut.value_table[2];
        n_cmp++;
        if (obs !== 16'sd100) begin n_bad++; $display("FAIL rw_table2 got %0d want 100", obs); end
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || action_data !== 2'(e) || e != 2) begin n_bad++; $display("FAIL rw_action_2 got %0d want 2", action_data); end
        accept_action();
        n_cmp++;
        if (reward_ready !== 1'b1) begin n_bad++; $display("FAIL rw_in_wait got %b want 1", reward_ready); end
        #2 reset = 1'b0;
        #1;
        n_cmp++;
        if (action_valid !== 1'b0 || action_data !== 2'd0 || reward_ready !== 1'b0) begin
            n_bad++; $display("FAIL rw_reset_outputs got v=%b d=%0d r=%b want 0 0 0", action_valid, action_data, reward_ready);
        end
        @(negedge clock);
        model_clear();
        reset = 1'b1;
        wait_action(ok, cyc);
        n_cmp++;
        if (!ok || cyc != 2 * ARMS + 1) begin n_bad++; $display("FAIL rw_latency got %0d want %0d", cyc, 2 * ARMS + 1); end
        e = exp_q.pop_front();
        n_cmp++;
        if (action_data !== 2'(e)) begin n_bad++; $display("FAIL rw_after_reset got %0d want %0d", action_data, e); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int cyc;
        int e;
        int r;
        logic signed [DW-1:0] obs;
        apply_reset();
        for (int k = 0; k < 24; k++) begin
            wait_action(ok, cyc);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || action_data !== 2'(e)) begin n_bad++; $display("FAIL b2b_action[%0d] got %0d want %0d", k, action_data, e); end
            if (k == 0)      r = 32767;
            else if (k == 1) r = -32768;
            else             r = $urandom_range(0, 4000) - 2000;
            accept_action();
            give_reward(r, ok);
            model[e] = model_update(model[e], r);
            exp_q.push_back(model_greedy());
        end
        wait_action(ok, cyc);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || action_data !== 2'(e)) begin n_bad++; $display("FAIL b2b_final_action got %0d want %0d", action_data, e); end
        for (int i = 0; i < ARMS; i++) begin
            obs = dut.value_table[i];
            n_cmp++;
            if (obs !== 16'(model[i])) begin n_bad++; $display("FAIL b2b_table[%0d] got %0d want %0d", i, obs, model[i]); end
        end
    endtask

    task automatic test_explore();
        bit ok;
        int cyc;
        logic [3:0] seen;
        logic [3:0] want;
        apply_reset();
        epsilon = 8'd255;
        seen = '0;
        for (int k = 0; k < 1000; k++) begin
            wait_action(ok, cyc);
            if (!ok) break;
            seen[action_data] = 1'b1;
            accept_action();
            give_reward(0, ok);
        end
`ifdef BANDIT_EXPLORE_EN
        want = 4'hF;
`else
        want = 4'h1;
`endif
        n_cmp++;
        if (seen !== want) begin n_bad++; $display("FAIL explore_eps255 got %b want %b", seen, want); end
        epsilon = 8'd0;
        seen = '0;
        for (int k = 0; k < 100; k++) begin
            wait_action(ok, cyc);
            if (!ok) break;
            seen[action_data] = 1'b1;
            accept_action();
            give_reward(0, ok);
        end
        n_cmp++;
        if (seen !== 4'h1) begin n_bad++; $display("FAIL explore_eps0 got %b want 0001", seen); end
    endtask

    initial begin
        reset        = 1'b1;
        reward_valid = 1'b0;
        reward_data  = '0;
        action_ready = 1'b0;
        epsilon      = 8'd0;
        test_reset();
        test_update_positive();
        test_update_negative();
        test_stall();
        test_reset_in_wait();
        test_back_to_back();
        test_explore();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
